// File: rtl/seq_detector_param.sv
// Runtime-programmable Mealy serial sequence detector with selectable overlap mode.
// Defining SEQDET_COUNT_EN adds a saturating match counter; otherwise match_count_o is tied to 0.
module seq_detector_param #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   pat_len_i,
    input  logic               overlap_en_i,
    input  logic               in_valid_i,
    input  logic               data_in_i,
    output logic               data_out_o,
    output logic [CNT_W-1:0]   match_count_o,
    output logic               busy_o
);
    localparam int unsigned FillW = $clog2(MAX_LEN);
    localparam logic [FillW-1:0] FillMax = FillW'(MAX_LEN - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] cfg_pat_q, cfg_pat_d;
    logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
    logic               cfg_ovl_q, cfg_ovl_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [FillW-1:0]   fill_q, fill_d;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   len_clamped;
    logic               match;

    // Newest bit sits in bit 0, so the low cfg_len bits line up with cfg_pat.
    assign window = {hist_q, data_in_i};

    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < cfg_len_q);
        end
    end

    always_comb begin
        match = 1'b0;
        if (state_q == StRun && in_valid_i && !cfg_load_i) begin
            match = (LEN_W'(fill_q) >= cfg_len_q - LEN_W'(1)) &&
                    (((window ^ cfg_pat_q) & len_mask) == '0);
        end
    end

    assign data_out_o = match;
    assign busy_o     = (state_q == StRun);

    always_comb begin
        if (pat_len_i == '0) begin
            len_clamped = LEN_W'(1);
        end else if (pat_len_i > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end else begin
            len_clamped = pat_len_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        cfg_pat_d = cfg_pat_q;
        cfg_len_d = cfg_len_q;
        cfg_ovl_d = cfg_ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;

        if (cfg_load_i) begin
            state_d   = StRun;
            cfg_pat_d = pattern_i;
            cfg_len_d = len_clamped;
            cfg_ovl_d = overlap_en_i;
            hist_d    = '0;
            fill_d    = '0;
        end else if (state_q == StRun && in_valid_i) begin
            hist_d = window[MAX_LEN-2:0];
            // Non-overlap: forget the matched window so none of it is reused.
            if (match && !cfg_ovl_q) begin
                fill_d = '0;
            end else if (fill_q != FillMax) begin
                fill_d = fill_q + FillW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cfg_pat_q <= '0;
            cfg_len_q <= LEN_W'(1);
            cfg_ovl_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            cfg_pat_q <= cfg_pat_d;
            cfg_len_q <= cfg_len_d;
            cfg_ovl_q <= cfg_ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (cfg_load_i) begin
            count_d = '0;
        end else if (match && count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count_o = count_q;
`else
    assign match_count_o = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_seq_detector_param;
    localparam int unsigned MaxLen = 8;
    localparam int unsigned LenW   = $clog2(MaxLen + 1);
    localparam int unsigned CntW   = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              cfg_load_i = 1'b0;
    logic [MaxLen-1:0] pattern_i = '0;
    logic [LenW-1:0]   pat_len_i = '0;
    logic              overlap_en_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              data_in_i = 1'b0;
    logic              data_out_o, busy_o;
    logic [CntW-1:0]   match_count_o;
    logic              sat_data_out, sat_busy;
    logic [1:0]        sat_count;

    int total = 0;
    int bad = 0;

    seq_detector_param #(.MAX_LEN(MaxLen), .CNT_W(CntW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_load_i(cfg_load_i), .pattern_i(pattern_i),
        .pat_len_i(pat_len_i), .overlap_en_i(overlap_en_i), .in_valid_i(in_valid_i),
        .data_in_i(data_in_i), .data_out_o(data_out_o), .match_count_o(match_count_o),
        .busy_o(busy_o)
    );

    // Narrow-counter copy sharing all inputs, used for the saturation check.
    seq_detector_param #(.MAX_LEN(MaxLen), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_load_i(cfg_load_i), .pattern_i(pattern_i),
        .pat_len_i(pat_len_i), .overlap_en_i(overlap_en_i), .in_valid_i(in_valid_i),
        .data_in_i(data_in_i), .data_out_o(sat_data_out), .match_count_o(sat_count),
        .busy_o(sat_busy)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: accepted bits since the last load / non-overlap match.
    bit              m_run = 1'b0;
    bit [MaxLen-1:0] m_pat = '0;
    int              m_len = 1;
    bit              m_ovl = 1'b0;
    bit              m_bits[$];
    int              m_cnt = 0;
    int              m_cnt2 = 0;

    typedef struct {
        bit              ld;
        bit [MaxLen-1:0] pat;
        int              len;
        bit              ovl;
        bit              v;
        bit              d;
        bit              exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_match(input bit d);
        int n;
        if (!m_run) return 1'b0;
        n = m_bits.size();
        if (n + 1 < m_len) return 1'b0;
        if (d != m_pat[0]) return 1'b0;
        for (int i = 1; i < m_len; i++) begin
            if (m_bits[n - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic longint exp_count(input int c);
`ifdef SEQDET_COUNT_EN
        return longint'(c);
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_pat = '0;
        m_len = 1;
        m_ovl = 1'b0;
        m_bits.delete();
        m_cnt = 0;
        m_cnt2 = 0;
    endtask

    task automatic step(input bit ld, input bit [MaxLen-1:0] pat, input int len, input bit ovl,
                        input bit v, input bit d, output bit dout);
        bit exp_m;
        @(negedge clk_i);
        cfg_load_i   = ld;
        pattern_i    = pat;
        pat_len_i    = LenW'(len);
        overlap_en_i = ovl;
        in_valid_i   = v;
        data_in_i    = d;
        #1;
        exp_m = (!ld && v) ? model_match(d) : 1'b0;
        check("data_out", data_out_o, exp_m);
        check("busy", busy_o, m_run);
        check("match_count", match_count_o, exp_count(m_cnt));
        check("sat_count", sat_count, exp_count(m_cnt2));
        dout = data_out_o;
        @(posedge clk_i);
        if (ld) begin
            m_run = 1'b1;
            m_pat = pat;
            m_len = (len == 0) ? 1 : (len > MaxLen ? MaxLen : len);
            m_ovl = ovl;
            m_bits.delete();
            m_cnt = 0;
            m_cnt2 = 0;
        end else if (m_run && v) begin
            if (exp_m) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (exp_m && !m_ovl) begin
                m_bits.delete();
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() > MaxLen - 1) void'(m_bits.pop_front());
            end
        end
    endtask

    task automatic add_load(input bit [MaxLen-1:0] pat, input int len, input bit ovl);
        tbl.push_back('{ld: 1'b1, pat: pat, len: len, ovl: ovl, v: 1'b0, d: 1'b0, exp: 1'b0});
    endtask

    task automatic add_beat(input bit v, input bit d, input bit exp);
        tbl.push_back('{ld: 1'b0, pat: '0, len: 0, ovl: 1'b0, v: v, d: d, exp: exp});
    endtask

    task automatic beat(input bit v, input bit d, output bit dout);
        step(1'b0, '0, 0, 1'b0, v, d, dout);
    endtask

    initial begin
        bit dout;
        bit [MaxLen-1:0] rpat;
        int sat_exp[5] = '{1, 2, 3, 3, 3};

        // Reset state, then beats before any load are ignored.
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_data_out", data_out_o, 0);
        check("reset_count", match_count_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        beat(1'b1, 1'b1, dout);
        beat(1'b1, 1'b0, dout);

        // "110" overlap
        add_load(8'b110, 3, 1'b1);
        add_beat(1, 1, 0); add_beat(1, 1, 0); add_beat(1, 0, 1);
        add_beat(1, 1, 0); add_beat(1, 1, 0); add_beat(1, 0, 1);
        // "1010" overlap then non-overlap
        add_load(8'b1010, 4, 1'b1);
        add_beat(1, 1, 0); add_beat(1, 0, 0); add_beat(1, 1, 0); add_beat(1, 0, 1);
        add_beat(1, 1, 0); add_beat(1, 0, 1); add_beat(1, 1, 0);
        add_load(8'b1010, 4, 1'b0);
        add_beat(1, 1, 0); add_beat(1, 0, 0); add_beat(1, 1, 0); add_beat(1, 0, 1);
        add_beat(1, 1, 0); add_beat(1, 0, 0); add_beat(1, 1, 0);
        // "11" overlap with a valid gap
        add_load(8'b11, 2, 1'b1);
        add_beat(1, 1, 0); add_beat(0, 0, 0); add_beat(1, 1, 1); add_beat(1, 1, 1);
        // pat_len=0 clamps to 1
        add_load(8'b1, 0, 1'b0);
        add_beat(1, 1, 1); add_beat(1, 0, 0); add_beat(1, 1, 1);
        // pat_len=MAX_LEN+3 clamps to MAX_LEN
        add_load(8'b10110011, MaxLen + 3, 1'b1);
        add_beat(1, 1, 0); add_beat(1, 0, 0); add_beat(1, 1, 0); add_beat(1, 1, 0);
        add_beat(1, 0, 0); add_beat(1, 0, 0); add_beat(1, 1, 0); add_beat(1, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].v, tbl[i].d, dout);
            if (!tbl[i].ld) check($sformatf("vec%0d", i), dout, tbl[i].exp);
            if (i == 6) begin
                #1;
                check("count_110", match_count_o, exp_count(2));
            end
        end

        // Reset mid-pattern discards history and returns to idle.
        step(1'b1, 8'b110, 3, 1'b1, 1'b0, 1'b0, dout);
        beat(1'b1, 1'b1, dout);
        beat(1'b1, 1'b1, dout);
        #3;
        rst_ni = 1'b0;
        #1;
        check("rst_async_busy", busy_o, 0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        beat(1'b1, 1'b0, dout);
        check("rst_no_match", dout, 0);
        beat(1'b1, 1'b0, dout);
        step(1'b1, 8'b110, 3, 1'b1, 1'b0, 1'b0, dout);
        beat(1'b1, 1'b0, dout);
        check("rst_reload_no_match", dout, 0);

        // Counter saturation on the 2-bit instance, then clear by reload.
        step(1'b1, 8'b1, 1, 1'b1, 1'b0, 1'b0, dout);
        for (int k = 0; k < 5; k++) begin
            beat(1'b1, 1'b1, dout);
            #1;
            check($sformatf("sat%0d", k), sat_count, exp_count(sat_exp[k]));
        end
        step(1'b1, 8'b1, 1, 1'b1, 1'b0, 1'b0, dout);
        #1;
        check("sat_clear", sat_count, 0);

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                rpat = MaxLen'($urandom);
                step(1'b1, rpat, $urandom_range(0, MaxLen + 3), 1'($urandom), 1'b0, 1'b0, dout);
            end else begin
                beat($urandom_range(0, 3) != 0, 1'($urandom), dout);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
